// File: rtl/data_mem_responder.sv
// Word-addressed data memory with byte-enable writes, registered read data,
// optional fixed wait states and sticky error flags for out-of-range and read/write collisions.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic [3:0]  byte_select,
    output logic [31:0] data_in,
    output logic        memReady,
    output logic        addr_err,
    output logic        rd_drop
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  wcnt_reg, wcnt_next;
    logic        mem_ready_reg, mem_ready_next;
    logic        addr_err_reg;
    logic        rd_drop_reg;

    logic [31:0]   offset;
    logic          req_in_range;
    logic [AW-1:0] req_idx;
    logic          accept;
    logic          done;

    // Operation actually applied to the array this cycle (live or captured).
    logic          op_fire;
    logic          op_rd;
    logic          op_wr;
    logic          op_in_range;
    logic [AW-1:0] op_idx;
    logic [31:0]   op_data;
    logic [3:0]    op_be;

    assign offset       = data_addr - BASE_ADDR;
    assign req_in_range = (data_addr >= BASE_ADDR) && (offset < SPAN);
    assign req_idx      = offset[AW+1:2];
    assign accept       = (state_reg == IDLE) && (ren || wen);
    assign done         = (state_reg == BUSY) && (wcnt_reg == 3'd1);

    generate
        if (WAIT_STATES == 0) begin : g_direct
            assign op_fire     = accept;
            assign op_rd       = ren;
            assign op_wr       = wen && !ren;
            assign op_in_range = req_in_range;
            assign op_idx      = req_idx;
            assign op_data     = data_out;
            assign op_be       = byte_select;
        end else begin : g_captured
            logic          cap_rd_reg;
            logic          cap_wr_reg;
            logic          cap_in_range_reg;
            logic [AW-1:0] cap_idx_reg;
            logic [31:0]   cap_data_reg;
            logic [3:0]    cap_be_reg;

            // Request is frozen at accept so bus activity during BUSY is ignored.
            always_ff @(posedge clock) begin
                if (reset) begin
                    cap_rd_reg <= 1'b0;
                    cap_wr_reg <= 1'b0;
                end else if (accept) begin
                    cap_rd_reg       <= ren;
                    cap_wr_reg       <= wen && !ren;
                    cap_in_range_reg <= req_in_range;
                    cap_idx_reg      <= req_idx;
                    cap_data_reg     <= data_out;
                    cap_be_reg       <= byte_select;
                end
            end

            assign op_fire     = done;
            assign op_rd       = cap_rd_reg;
            assign op_wr       = cap_wr_reg;
            assign op_in_range = cap_in_range_reg;
            assign op_idx      = cap_idx_reg;
            assign op_data     = cap_data_reg;
            assign op_be       = cap_be_reg;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            wcnt_reg      <= 3'd0;
            mem_ready_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            wcnt_reg      <= wcnt_next;
            mem_ready_reg <= mem_ready_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wcnt_next      = wcnt_reg;
        mem_ready_next = mem_ready_reg;
        case (state_reg)
            IDLE: begin
                if (accept && (WAIT_STATES != 0)) begin
                    state_next     = BUSY;
                    wcnt_next      = 3'(WAIT_STATES);
                    mem_ready_next = 1'b0;
                end
            end
            BUSY: begin
                wcnt_next = wcnt_reg - 3'd1;
                if (done) begin
                    state_next     = IDLE;
                    mem_ready_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_err_reg <= 1'b0;
            rd_drop_reg  <= 1'b0;
        end else begin
            if (accept && !req_in_range) begin
                addr_err_reg <= 1'b1;
            end
            if (accept && ren && wen) begin
                rd_drop_reg <= 1'b1;
            end
        end
    end

    // One narrow array per byte lane keeps byte-enable writes block-RAM friendly.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clock) begin
                if (!reset && op_fire && op_wr && op_in_range && op_be[gi]) begin
                    lane_mem[op_idx] <= op_data[8*gi +: 8];
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    rd_byte_reg <= 8'h00;
                end else if (op_fire && op_rd) begin
                    rd_byte_reg <= op_in_range ? lane_mem[op_idx] : 8'h00;
                end
            end

            assign data_in[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    assign memReady = mem_ready_reg;
    assign addr_err = addr_err_reg;
    assign rd_drop  = rd_drop_reg;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, words of storage (power of two, 16..4096).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra stall cycles per access (0..7).
REQ-004 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ren  input  1  read request.
REQ-007 SHALL have port wen  input  1  write request.
REQ-008 SHALL have port data_addr  input  32  byte address of the access.
REQ-009 SHALL have port data_out  input  32  write data from the requester.
REQ-010 SHALL have port byte_select  input  4  write byte enables; bit i covers bits [8i+7:8i].
REQ-011 SHALL have port data_in  output  32  read data to the requester (registered).
REQ-012 SHALL have port memReady  output  1  high = idle/complete; low = requester must stall (registered).
REQ-013 SHALL have port addr_err  output  1  sticky flag: out-of-range access occurred.
REQ-014 SHALL have port rd_drop  output  1  sticky flag: ren and wen were asserted in the same accept cycle.

Function
REQ-015 SHALL decode word index as (data_addr - BASE_ADDR) >> 2; data_addr[1:0] ignored; in range iff data_addr >= BASE_ADDR and index < DEPTH_WORDS.
REQ-016 SHALL implement FSM states IDLE and BUSY plus down-counter wcnt of width 3.
REQ-017 SHALL, in IDLE, accept a request in any cycle where ren or wen is high, capturing the address, data_out, byte_select and operation.
REQ-018 SHALL, when ren and wen are both high in an accept cycle, service the read, discard the write, and set rd_drop.
REQ-019 SHALL, with WAIT_STATES=0, stay in IDLE with memReady held at 1; read accepted in cycle N -> data_in = mem[index] from cycle N+1; write accepted in cycle N -> memory updated at the end of cycle N.
REQ-020 SHALL, with WAIT_STATES=W>0, on accept in cycle N load wcnt=W, enter BUSY, and drive memReady=0 during cycles N+1..N+W.
REQ-021 SHALL, in BUSY, decrement wcnt each cycle; when wcnt reaches 1, commit the captured write or load data_in with the captured read, then return to IDLE, with memReady=1 and data_in valid from cycle N+W+1.
REQ-022 SHALL ignore ren, wen, data_addr, data_out and byte_select while in BUSY.
REQ-023 SHALL hold data_in unchanged except on completion of a read.
REQ-024 SHALL update only the bytes whose byte_select bit is 1 on a write; byte_select=0000 leaves memory unchanged but still completes the access with normal timing.
REQ-025 SHALL, on an out-of-range access, suppress any memory write, return 32'h0 as read data, set addr_err, and use normal timing.
REQ-026 SHALL treat each ren or wen sampled in IDLE as a new request, including a request in the cycle immediately after completion.
REQ-027 SHALL, for a read and a write to the same word in consecutive accepts, return the newly written data (read-after-write coherent).

Reset
REQ-028 SHALL, while reset=1 at a clock edge, set state=IDLE, wcnt=0, memReady=1, data_in=0, addr_err=0 and rd_drop=0.
REQ-029 SHALL, if reset is asserted while in BUSY, abandon the pending access; a captured write SHALL NOT be committed.
REQ-030 SHALL NOT clear memory contents on reset.

Verification
REQ-031 W=0: write 32'hDEADBEEF to 0x10 with byte_select=1111, then read 0x10 -> data_in=32'hDEADBEEF one cycle after the read; memReady constant 1.
REQ-032 W=0: word 0x20 = 32'h11223344; write 32'hAABBCCDD with byte_select=0101 -> subsequent read returns 32'h11BB33DD.
REQ-033 W=3: read accepted in cycle N -> memReady=0 in cycles N+1..N+3, =1 in cycle N+4 with data valid; inputs changed during BUSY have no effect.
REQ-034 DEPTH_WORDS=256: write to 0x400 -> addr_err=1 and no memory word changes; read of 0x400 -> data_in=0.
REQ-035 ren=wen=1 at 0x8 -> read data returned, memory at 0x8 unchanged, rd_drop=1; a subsequent reset clears rd_drop and addr_err.
REQ-036 W=2: assert reset in cycle N+1 after a write accept in cycle N -> memory word unchanged, memReady=1 after reset.
